pipelined_adder: RTL and testbench

Parametrised, carry-pipelined add/subtract unit; the next generation of the team's 64-bit two-segment adder. Operand width and segment width are generic. Each pipeline stage resolves one segment and registers the carry between stages, so long adders close timing. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure. It sits between operand-issue logic and the result writeback/accumulator path.

---
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Carry-pipelined add/subtract unit. One SEG_WIDTH slice of the result is
// resolved per stage, and the carry between slices is registered. Operand
// slices that are not yet consumed travel in skew registers. Result slices
// that are already finished travel in the de-skew (result) registers. The
// whole pipeline advances together under a valid/ready handshake.
module pipelined_adder #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_WIDTH;
    localparam int SEG  = SEG_WIDTH;

    // Per-stage state. Stage NSEG-1 doubles as the output register.
    logic [NSEG-1:0]  valid_reg;
    logic [NSEG-1:0]  carry_reg;
    logic [NSEG-1:0]  sub_reg;
    logic [WIDTH-1:0] res_reg [NSEG];
    logic             ovf_reg;

    // Subtraction is an addition of the inverted B with an inverted borrow.
    logic [WIDTH-1:0] b_adj;
    logic             c_eff;
    logic             adv;

    // Combinational slice sums, one per stage. The MSB is the carry out of the slice.
    logic [SEG:0]     seg_sum [NSEG];
    // Top bit of the operands seen by the last stage, used for overflow.
    logic             last_a_msb;
    logic             last_b_msb;

    assign b_adj    = sub ? ~din_two : din_two;
    assign c_eff    = cin ^ sub;
    assign in_ready = ~valid_reg[NSEG-1] | out_ready;
    assign adv      = in_ready;

    assign seg_sum[0] = {1'b0, din_one[SEG-1:0]} + {1'b0, b_adj[SEG-1:0]}
                      + {{SEG{1'b0}}, c_eff};

    if (NSEG == 1) begin : g_single
        assign last_a_msb = din_one[WIDTH-1];
        assign last_b_msb = b_adj[WIDTH-1];
    end else begin : g_skew
        // The skew entry at index k holds the full operands as seen by stage k.
        logic [WIDTH-1:0] a_skew_reg [NSEG-1];
        logic [WIDTH-1:0] b_skew_reg [NSEG-1];

        // Operand skew chain. It shifts with the pipeline and holds on a stall.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < NSEG - 1; k++) begin
                    a_skew_reg[k] <= '0;
                    b_skew_reg[k] <= '0;
                end
            end else if (adv) begin
                a_skew_reg[0] <= din_one;
                b_skew_reg[0] <= b_adj;
                for (int k = 1; k < NSEG - 1; k++) begin
                    a_skew_reg[k] <= a_skew_reg[k-1];
                    b_skew_reg[k] <= b_skew_reg[k-1];
                end
            end
        end

        for (genvar gi = 1; gi < NSEG; gi++) begin : g_seg
            assign seg_sum[gi] = {1'b0, a_skew_reg[gi-1][gi*SEG +: SEG]}
                               + {1'b0, b_skew_reg[gi-1][gi*SEG +: SEG]}
                               + {{SEG{1'b0}}, carry_reg[gi-1]};
        end

        assign last_a_msb = a_skew_reg[NSEG-2][WIDTH-1];
        assign last_b_msb = b_skew_reg[NSEG-2][WIDTH-1];
    end

    // Stage registers. Valid bits, carries and result slices move as one
    // shift, so bubbles are never collapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            sub_reg   <= '0;
            ovf_reg   <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                res_reg[k] <= '0;
            end
        end else if (adv) begin
            valid_reg[0] <= in_valid;
            carry_reg[0] <= seg_sum[0][SEG];
            sub_reg[0]   <= sub;
            res_reg[0]   <= WIDTH'(seg_sum[0][SEG-1:0]);
            for (int k = 1; k < NSEG; k++) begin
                valid_reg[k]                <= valid_reg[k-1];
                carry_reg[k]                <= seg_sum[k][SEG];
                sub_reg[k]                  <= sub_reg[k-1];
                res_reg[k]                  <= res_reg[k-1];
                res_reg[k][k*SEG +: SEG]    <= seg_sum[k][SEG-1:0];
            end
            // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
            ovf_reg <= last_a_msb ^ last_b_msb
                     ^ seg_sum[NSEG-1][SEG-1] ^ seg_sum[NSEG-1][SEG];
        end
    end

    assign out_valid = valid_reg[NSEG-1];
    assign sum       = res_reg[NSEG-1];
    // In subtract mode the internal carry is inverted to present a borrow.
    assign cout      = carry_reg[NSEG-1] ^ sub_reg[NSEG-1];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder. Three instances cover the
// configurations 64/32, 64/16 and 48/48. The stimulus pushes the expected
// results into per-instance queues. Per-instance monitors pop those queues
// and compare each result that leaves the unit.
module tb_pipelined_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          stamp;
    } exp_t;

    function automatic int w_of(input int i);
        return (i == 2) ? 48 : 64;
    endfunction

    function automatic int s_of(input int i);
        return (i == 0) ? 32 : ((i == 1) ? 16 : 48);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid    [3];
    logic        out_ready   [3];
    logic        cin_i       [3];
    logic        sub_i       [3];
    logic [63:0] a_i         [3];
    logic [63:0] b_i         [3];
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic        cout_o      [3];
    logic        ovf_o       [3];
    logic [63:0] sum_o       [3];

    exp_t exp_q [3][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_on = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W  = w_of(gi);
        localparam int S  = s_of(gi);
        localparam int NS = W / S;
        logic [W-1:0] sum_w;
        logic         hold_v = 1'b0;
        logic [65:0]  hold_d;
        exp_t         e;

        pipelined_adder #(.WIDTH(W), .SEG_WIDTH(S)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready_o[gi]),
            .din_one   (a_i[gi][W-1:0]),
            .din_two   (b_i[gi][W-1:0]),
            .cin       (cin_i[gi]),
            .sub       (sub_i[gi]),
            .out_valid (out_valid_o[gi]),
            .out_ready (out_ready[gi]),
            .sum       (sum_w),
            .cout      (cout_o[gi]),
            .ovf       (ovf_o[gi])
        );
        assign sum_o[gi] = 64'(sum_w);

        // Monitor: handshake rule, stall stability, and scoreboard pop.
        always @(negedge clk) begin
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                chk($sformatf("dut%0d in_ready", gi), 64'(in_ready_o[gi]),
                    64'(!out_valid_o[gi] || out_ready[gi]));
                if (hold_v)
                    chk($sformatf("dut%0d stall_hold", gi),
                        {out_valid_o[gi], sum_o[gi][62:0]} ^ 64'(hold_d[65:64]),
                        {1'b1, hold_d[62:0]} ^ 64'(hold_d[65:64]));
                if (hold_v)
                    chk($sformatf("dut%0d stall_hold_top", gi),
                        {61'd0, sum_o[gi][63], cout_o[gi], ovf_o[gi]},
                        {61'd0, hold_d[63], hold_d[65:64]});
                hold_v = out_valid_o[gi] && !out_ready[gi];
                hold_d = {cout_o[gi], ovf_o[gi], sum_o[gi]};
                if (out_valid_o[gi] && out_ready[gi]) begin
                    if (exp_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d ghost: got sum %h with empty queue expected no output",
                                 gi, sum_o[gi]);
                    end else begin
                        e = exp_q[gi].pop_front();
                        chk($sformatf("dut%0d sum", gi), sum_o[gi], e.s);
                        chk($sformatf("dut%0d cout", gi), 64'(cout_o[gi]), 64'(e.c));
                        chk($sformatf("dut%0d ovf", gi), 64'(ovf_o[gi]), 64'(e.o));
                        if (lat_on)
                            chk($sformatf("dut%0d latency", gi), 64'(cyc - e.stamp), 64'(NS));
                        $display("dut%0d result sum=%h cout=%0b ovf=%0b", gi, sum_o[gi],
                                 cout_o[gi], ovf_o[gi]);
                    end
                end
            end
        end
    end

    // Reference model written from the arithmetic definition. It computes
    // the full sum and derives overflow from the operand and result signs.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb);
        exp_t        r;
        logic [63:0] mask;
        logic [63:0] bb;
        logic [64:0] full;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        bb   = (sb ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + 65'(ci ^ sb);
        r.s  = full[63:0] & mask;
        r.c  = full[w] ^ sb;
        r.o  = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
        r.stamp = 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
        exp_t r;
        r.s = s; r.c = c; r.o = o; r.stamp = 0;
        return r;
    endfunction

    // Drive one cycle. The expectation is queued only if the unit accepts.
    task automatic cycle_drive(input int d, input bit v, input logic [63:0] a, input logic [63:0] b,
                               input bit ci, input bit sb, input bit ordy, input exp_t e,
                               output bit acc);
        in_valid[d]  = v;
        a_i[d]       = a;
        b_i[d]       = b;
        cin_i[d]     = ci;
        sub_i[d]     = sb;
        out_ready[d] = ordy;
        @(negedge clk);
        acc = v && in_ready_o[d] && !rst;
        if (acc) begin
            e.stamp = cyc;
            exp_q[d].push_back(e);
            $display("dut%0d issue a=%h b=%h cin=%0b sub=%0b", d, a, b, ci, sb);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [63:0] a, input logic [63:0] b,
                        input bit ci, input bit sb, input exp_t e);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            cycle_drive(d, 1'b1, a, b, ci, sb, 1'b1, e, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept_timeout: got no accept expected accept within 50 cycles", d);
        end
    endtask

    task automatic send_rand(input int d);
        logic [63:0] a, b, mask;
        bit          ci, sb;
        int          w;
        w    = w_of(d);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = {$urandom, $urandom} & mask;
        b    = {$urandom, $urandom} & mask;
        if ($urandom_range(0, 9) == 0) a = mask;
        if ($urandom_range(0, 9) == 0) b = mask;
        ci   = 1'($urandom_range(0, 1));
        sb   = 1'($urandom_range(0, 1));
        send(d, a, b, ci, sb, model(w, a, b, ci, sb));
    endtask

    task automatic wait_empty(input int d);
        int n;
        n = 0;
        out_ready[d] = 1'b1;
        while (exp_q[d].size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q[d].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d drain_timeout: got %0d pending expected 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
    endtask

    task automatic check_idle(input int d);
        chk($sformatf("dut%0d rst_out_valid", d), 64'(out_valid_o[d]), 64'd0);
        chk($sformatf("dut%0d rst_sum", d), sum_o[d], 64'd0);
        chk($sformatf("dut%0d rst_cout", d), 64'(cout_o[d]), 64'd0);
        chk($sformatf("dut%0d rst_ovf", d), 64'(ovf_o[d]), 64'd0);
        chk($sformatf("dut%0d rst_in_ready", d), 64'(in_ready_o[d]), 64'd1);
    endtask

    // Watchdog: ends the run if the stimulus ever stops making progress.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra [6];
        logic [63:0] rb [6];
        bit          rc [6];
        bit          rs [6];
        bit          pat [4];
        bit          acc;
        int          idx, t;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            cin_i[i] = 1'b0; sub_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i);
        @(posedge clk);
        #1;

        // Directed vectors for 64/32 with hand-computed results.
        send(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h0000_0001_0000_0000, 1'b0, 1'b0));
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, mk(64'd0, 1'b1, 1'b0));
        send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
        send(0, 64'd5, 64'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0));
        send(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1));
        send(0, 64'd10, 64'd3, 1'b1, 1'b1, mk(64'd6, 1'b0, 1'b0));
        send(0, 64'd0, 64'd0, 1'b1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
        send(0, 64'd3, 64'd4, 1'b0, 1'b0, mk(64'd7, 1'b0, 1'b0));
        wait_empty(0);
        // Carries crossing every 16-bit boundary, and a full 48-bit wrap.
        send(1, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h0001_0000_0000_0000, 1'b0, 1'b0));
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, mk(64'd0, 1'b1, 1'b0));
        send(2, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'd0, 1'b1, 1'b0));
        send(2, 64'h0000_7FFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h0000_8000_0000_0000, 1'b0, 1'b1));
        wait_empty(1);
        wait_empty(2);

        // Backpressure: six random sets while out_ready follows 1,0,0,1.
        lat_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        t = 0;
        while (idx < 6 && t < 200) begin
            cycle_drive(0, 1'b1, ra[idx], rb[idx], rc[idx], rs[idx], pat[t % 4],
                        model(64, ra[idx], rb[idx], rc[idx], rs[idx]), acc);
            if (acc) idx++;
            t++;
        end
        chk("bp_accepted", 64'(idx), 64'd6);
        wait_empty(0);

        // Reset with two items in flight, with in_valid held high during reset.
        out_ready[0] = 1'b0;
        cycle_drive(0, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, mk(64'd3, 1'b0, 1'b0), acc);
        cycle_drive(0, 1'b1, 64'd4, 64'd5, 1'b0, 1'b0, 1'b0, mk(64'd9, 1'b0, 1'b0), acc);
        rst = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check_idle(0);
        repeat (8) @(posedge clk);
        #1;
        lat_on = 1'b1;

        // Random sweeps with a fixed out_ready of 1, where latency must equal NSEG.
        for (int i = 0; i < 1000; i++) send_rand(1);
        wait_empty(1);
        for (int i = 0; i < 1000; i++) send_rand(2);
        wait_empty(2);
        for (int i = 0; i < 50; i++) send_rand(0);
        wait_empty(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
